// File: rtl/tick_timer_sched_pkg.sv
// Shared definitions for the tick timer scheduler.
// Holds the per-channel FSM state encoding used by tick_timer_sched.
package tick_timer_sched_pkg;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

endpackage

// File: rtl/tick_timer_sched_tick_gen.sv
// tick_gen: shared slow-tick prescaler.
// Counts 0..CNT_MAX while enabled and emits a one-cycle registered tick once per period.
// When disabled, the counter is held at 0 so a restart always yields a full first period.
// Requires CNT_MAX >= 1.
// Ports:
//   sys_clk    in   system clock
//   sys_rst_n  in   asynchronous active-low reset
//   en         in   prescaler enable
//   tick       out  one-cycle tick, period CNT_MAX+1 clocks
module tick_gen #(
   parameter int unsigned CNT_MAX = 24_999_999
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic en,
   output logic tick
);

   localparam int unsigned CntW = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(CNT_MAX);
   localparam logic [CntW-1:0] CntPre  = CntW'(CNT_MAX - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            tick_d;

   always_comb begin
      cnt_d  = '0;
      tick_d = 1'b0;
      if (en) begin
         cnt_d  = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
         // Registered one cycle early so the tick lands on the wrap cycle.
         tick_d = (cnt_q == CntPre);
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_q <= '0;
         tick  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tick  <= tick_d;
      end
   end

endmodule

// File: rtl/tick_timer_sched.sv
// tick_timer_sched: multi-channel timeout scheduler sharing one slow-tick prescaler.
// Each channel loads a delay in ticks on req, counts it down on the shared tick and
// pulses done on expiry. The prescaler runs only while at least one channel is busy.
// Ports:
//   sys_clk    in   system clock
//   sys_rst_n  in   asynchronous active-low reset
//   req        in   per-channel start/restart strobe
//   dly        in   packed per-channel delays, channel i = dly[i*DLY_W +: DLY_W]
//   cancel     in   per-channel abort strobe (beats req)
//   busy       out  per-channel counting flag
//   done       out  per-channel one-cycle expiry pulse
//   tick       out  shared prescaler tick
//   any_busy   out  OR of busy, also the prescaler enable
module tick_timer_sched
   import tick_timer_sched_pkg::*;
#(
   parameter int unsigned CNT_MAX = 24_999_999,
   parameter int unsigned N_CH    = 4,
   parameter int unsigned DLY_W   = 8
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst_n,
   input  logic [N_CH-1:0]         req,
   input  logic [N_CH*DLY_W-1:0]   dly,
   input  logic [N_CH-1:0]         cancel,
   output logic [N_CH-1:0]         busy,
   output logic [N_CH-1:0]         done,
   output logic                    tick,
   output logic                    any_busy
);

   logic [N_CH-1:0] state_d;

   tick_gen #(
      .CNT_MAX (CNT_MAX)
   ) u_tick_gen (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .en        (any_busy),
      .tick      (tick)
   );

   for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
      logic [0:0]       st_q, st_d;
      logic [DLY_W-1:0] rem_q, rem_d;
      logic             done_q, done_d;
      logic [DLY_W-1:0] dly_i;

      assign dly_i = dly[i*DLY_W +: DLY_W];

      always_comb begin
         st_d   = st_q;
         rem_d  = rem_q;
         done_d = 1'b0;
         if (cancel[i]) begin
            st_d  = IDLE;
            rem_d = '0;
         end else if (req[i]) begin
            if (dly_i == '0) begin
               st_d   = IDLE;
               rem_d  = '0;
               done_d = 1'b1;
            end else begin
               // Restart reloads; a tick in the same cycle is deliberately dropped.
               st_d  = RUN;
               rem_d = dly_i;
            end
         end else if ((st_q == RUN) && tick) begin
            if (rem_q > DLY_W'(1)) begin
               rem_d = rem_q - 1'b1;
            end else begin
               st_d   = IDLE;
               rem_d  = '0;
               done_d = 1'b1;
            end
         end
      end

      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
         if (!sys_rst_n) begin
            st_q   <= IDLE;
            rem_q  <= '0;
            done_q <= 1'b0;
         end else begin
            st_q   <= st_d;
            rem_q  <= rem_d;
            done_q <= done_d;
         end
      end

      assign state_d[i] = (st_d == RUN);
      assign busy[i]    = (st_q == RUN);
      assign done[i]    = done_q;
   end

   // Built from next-state so the prescaler enables in the same cycle busy rises and a
   // same-cycle expiry/start handover keeps it running without a clear.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         any_busy <= 1'b0;
      end else begin
         any_busy <= |state_d;
      end
   end

endmodule

// File: tb/tb_tick_timer_sched.sv
// Self-checking bench for tick_timer_sched (CNT_MAX=4, N_CH=4, DLY_W=8).
// Directed scenarios with literal expectations, then randomized traffic checked every
// cycle against a behavioural model of the scheduler.
module tb_tick_timer_sched;

   localparam int CNT_MAX = 4;
   localparam int N_CH    = 4;
   localparam int DLY_W   = 8;
   localparam int P       = CNT_MAX + 1;

   logic                  sys_clk;
   logic                  sys_rst_n;
   logic [N_CH-1:0]       req;
   logic [N_CH*DLY_W-1:0] dly;
   logic [N_CH-1:0]       cancel;
   logic [N_CH-1:0]       busy;
   logic [N_CH-1:0]       done;
   logic                  tick;
   logic                  any_busy;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   tick_timer_sched #(
      .CNT_MAX (CNT_MAX),
      .N_CH    (N_CH),
      .DLY_W   (DLY_W)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .req       (req),
      .dly       (dly),
      .cancel    (cancel),
      .busy      (busy),
      .done      (done),
      .tick      (tick),
      .any_busy  (any_busy)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cycle=%0d actual=%0d required=%0d", nm, cyc, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Current-cycle expectations; k = cycles since the prescaler was last enabled.
   bit [N_CH-1:0] m_busy, m_done, n_busy, n_done;
   bit            m_tick, m_any, n_tick;
   int            m_rem [N_CH];
   int            n_rem [N_CH];
   int            k;
   int            d;

   initial begin
      m_busy = '0; m_done = '0; m_tick = 0; m_any = 0; k = 0;
      foreach (m_rem[c]) m_rem[c] = 0;
   end

   always @(negedge sys_clk) begin
      if (!sys_rst_n) begin
         m_busy = '0; m_done = '0; m_tick = 0; m_any = 0; k = 0;
         foreach (m_rem[c]) m_rem[c] = 0;
      end
      chk("model_busy", int'(busy), int'(m_busy));
      chk("model_done", int'(done), int'(m_done));
      chk("model_tick", int'(tick), int'(m_tick));
      chk("model_any_busy", int'(any_busy), int'(m_any));
      if (sys_rst_n) begin
         // Ticks fall on every P-th cycle of continuous enable, the first one P cycles in.
         n_tick = m_any && ((k % P) == P - 2);
         for (int c = 0; c < N_CH; c++) begin
            n_busy[c] = m_busy[c];
            n_rem[c]  = m_rem[c];
            n_done[c] = 0;
            d = int'(dly[c*DLY_W +: DLY_W]);
            if (cancel[c]) begin
               n_busy[c] = 0; n_rem[c] = 0;
            end else if (req[c]) begin
               if (d == 0) begin
                  n_done[c] = 1; n_busy[c] = 0; n_rem[c] = 0;
               end else begin
                  n_busy[c] = 1; n_rem[c] = d;
               end
            end else if (m_busy[c] && m_tick) begin
               n_rem[c] = m_rem[c] - 1;
               if (n_rem[c] == 0) begin
                  n_busy[c] = 0; n_done[c] = 1;
               end
            end
         end
         k = (|n_busy) ? (m_any ? k + 1 : 0) : 0;
         m_any  = |n_busy;
         m_busy = n_busy;
         m_done = n_done;
         m_tick = n_tick;
         foreach (m_rem[c]) m_rem[c] = n_rem[c];
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic next_cycle();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic set_dly(input int ch, input int v);
      dly[ch*DLY_W +: DLY_W] = DLY_W'(v);
   endtask

   task automatic idle(input int n);
      req = '0;
      cancel = '0;
      repeat (n) next_cycle();
   endtask

   initial begin
      sys_rst_n = 1'b0;
      req = '0;
      cancel = '0;
      dly = '0;
      @(negedge sys_clk);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_tick", int'(tick), 0);
      chk("reset_any_busy", int'(any_busy), 0);
      next_cycle();
      sys_rst_n = 1'b1;
      idle(4);

      // Idle start: ch0 dly=3.
      for (int r = 0; r <= 20; r++) begin
         req = (r == 0) ? 4'b0001 : 4'b0000;
         if (r == 0) set_dly(0, 3);
         @(negedge sys_clk);
         chk("s1_tick", int'(tick), int'(r == 5 || r == 10 || r == 15));
         chk("s1_done0", int'(done[0]), int'(r == 16));
         chk("s1_busy0", int'(busy[0]), int'(r >= 1 && r <= 15));
         next_cycle();
      end
      idle(4);

      // Zero delay on ch1.
      for (int r = 0; r <= 5; r++) begin
         req = (r == 0) ? 4'b0010 : 4'b0000;
         if (r == 0) set_dly(1, 0);
         @(negedge sys_clk);
         chk("s2_done1", int'(done[1]), int'(r == 1));
         chk("s2_busy1", int'(busy[1]), 0);
         chk("s2_tick", int'(tick), 0);
         next_cycle();
      end
      idle(4);

      // Cancel beats a same-cycle req on ch2.
      for (int r = 0; r <= 20; r++) begin
         req = (r == 0 || r == 3) ? 4'b0100 : 4'b0000;
         cancel = (r == 3) ? 4'b0100 : 4'b0000;
         if (r == 0) set_dly(2, 2);
         @(negedge sys_clk);
         if (r >= 4) chk("s3_busy2", int'(busy[2]), 0);
         chk("s3_done2", int'(done[2]), 0);
         next_cycle();
      end
      idle(4);

      // Restart on the first tick: tick ignored, done two ticks later.
      for (int r = 0; r <= 20; r++) begin
         req = (r == 0 || r == 5) ? 4'b0001 : 4'b0000;
         set_dly(0, 2);
         @(negedge sys_clk);
         chk("s4_done0", int'(done[0]), int'(r == 16));
         chk("s4_busy0", int'(busy[0]), int'(r >= 1 && r <= 15));
         next_cycle();
      end
      idle(4);

      // Simultaneous expiry on ch0 and ch3.
      for (int r = 0; r <= 8; r++) begin
         req = (r == 0) ? 4'b1001 : 4'b0000;
         set_dly(0, 1);
         set_dly(3, 1);
         @(negedge sys_clk);
         chk("s5_done", int'(done), (r == 6) ? 9 : 0);
         next_cycle();
      end
      idle(4);

      // Late joiner ch1 rides the running prescaler and gets an early first tick.
      for (int r = 0; r <= 18; r++) begin
         req = (r == 0) ? 4'b0001 : ((r == 7) ? 4'b0010 : 4'b0000);
         set_dly(0, 3);
         set_dly(1, 1);
         @(negedge sys_clk);
         chk("s5b_done1", int'(done[1]), int'(r == 11));
         chk("s5b_done0", int'(done[0]), int'(r == 16));
         chk("s5b_tick", int'(tick), int'(r == 5 || r == 10 || r == 15));
         next_cycle();
      end
      idle(4);

      // Reset mid-run.
      for (int r = 0; r <= 25; r++) begin
         req = (r == 0) ? 4'b0001 : 4'b0000;
         set_dly(0, 3);
         if (r == 7) begin
            #1;
            sys_rst_n = 1'b0;
         end
         if (r == 8) sys_rst_n = 1'b1;
         @(negedge sys_clk);
         if (r == 6) chk("s6_busy_pre", int'(busy[0]), 1);
         if (r >= 7) begin
            chk("s6_busy", int'(busy), 0);
            chk("s6_done", int'(done), 0);
            chk("s6_tick", int'(tick), 0);
            chk("s6_any_busy", int'(any_busy), 0);
         end
         next_cycle();
      end
      idle(4);

      // Randomized traffic, checked by the model.
      for (int r = 0; r < 3000; r++) begin
         if ($urandom_range(0, 799) == 0) begin
            req = '0;
            cancel = '0;
            sys_rst_n = 1'b0;
         end else begin
            sys_rst_n = 1'b1;
            for (int c = 0; c < N_CH; c++) begin
               req[c]    = ($urandom_range(0, 15) == 0);
               cancel[c] = ($urandom_range(0, 31) == 0);
               if ($urandom_range(0, 39) == 0) set_dly(c, 255);
               else if ($urandom_range(0, 9) == 0) set_dly(c, int'($urandom_range(0, 20)));
               else set_dly(c, int'($urandom_range(0, 4)));
            end
         end
         next_cycle();
      end
      sys_rst_n = 1'b1;
      idle(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
